// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multicycle control FSM for a small MIPS subset. It steps one instruction at a
// time through FETCH, DECODE, EXEC, MEM and WB, and drives the ALU, register
// file, data memory and PC strobes for the current step.
//
// Optional build macro MC_PERF_CNT_EN adds two 32-bit performance counters:
//   retired      - completed legal instructions
//   stall_cycles - cycles spent waiting on instr_valid in FETCH or on mem_ready in MEM
// Without the macro neither port exists.
//
// Strobes are decoded from the registered state plus the opcode/funct latched
// at fetch, so no path exists from the instruction bus to any output. The few
// inputs that do reach outputs are instr_valid (FETCH handshake) and zero
// (branch decision in EXEC). Both are qualified by the registered state.

module mips_multicycle_ctrl #(
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instruction,
  input  logic          instr_valid,
  input  logic          mem_ready,
  input  logic          zero,
  output logic [3:0]    ALU_control_lines,
  output logic          ALUsrc,
  output logic          ir_write,
  output logic          pc_write,
  output logic          pc_src,
  output logic          reg_write,
  output logic          reg_dst,
  output logic          mem_to_reg,
  output logic          mem_read,
  output logic          mem_write,
  output logic          illegal,
  output logic [2:0]    state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]   retired,
  output logic [31:0]   stall_cycles
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  stateT       r_state;
  stateT       w_nextState;
  logic [5:0]  r_opcode;
  logic [5:0]  r_funct;
  logic        r_rstHold;

  logic        w_accept;
  logic        w_isRtype;
  logic        w_isAdd;
  logic        w_isSub;
  logic        w_isAnd;
  logic        w_isOr;
  logic        w_isLw;
  logic        w_isSw;
  logic        w_isBeq;
  logic        w_isAddi;
  logic        w_isLegal;
  logic        w_useImm;
  logic [3:0]  w_aluOp;

  // Register fields between funct and opcode belong to the datapath, not to control.
  logic        w_unusedFields;
  assign w_unusedFields = ^instruction[25:6];

  // Stays high while reset is asserted and for the first cycle after release,
  // so that no strobe fires and no instruction is accepted in that window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rstHold <= 1'b1;
    else     r_rstHold <= 1'b0;
  end

  assign w_accept = (r_state == FETCH) && instr_valid && !r_rstHold;

  // Instruction-class decode from the latched fields only.
  assign w_isRtype = (r_opcode == OP_RTYPE);
  assign w_isAdd   = w_isRtype && (r_funct == FN_ADD);
  assign w_isSub   = w_isRtype && (r_funct == FN_SUB);
  assign w_isAnd   = w_isRtype && (r_funct == FN_AND);
  assign w_isOr    = w_isRtype && (r_funct == FN_OR);
  assign w_isLw    = (r_opcode == OP_LW);
  assign w_isSw    = (r_opcode == OP_SW);
  assign w_isBeq   = (r_opcode == OP_BEQ);
  assign w_isAddi  = (r_opcode == OP_ADDI);
  assign w_isLegal = w_isAdd | w_isSub | w_isAnd | w_isOr |
                     w_isLw | w_isSw | w_isBeq | w_isAddi;
  assign w_useImm  = w_isLw | w_isSw | w_isAddi;

  // ALU operation for the latched instruction; held constant from EXEC to WB.
  always_comb begin
    w_aluOp = ALU_ADD;
    if (w_isSub || w_isBeq) w_aluOp = ALU_SUB;
    else if (w_isAnd)       w_aluOp = ALU_AND;
    else if (w_isOr)        w_aluOp = ALU_OR;
  end

  // Capture opcode and funct when FETCH accepts a word; reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opcode <= 6'd0;
      r_funct  <= 6'd0;
    end else if (w_accept) begin
      r_opcode <= instruction[31:26];
      r_funct  <= instruction[5:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_nextState;
  end

  // Next-state and strobe decode. All outputs default to 0, so any state or
  // phase that does not name a strobe leaves it low.
  always_comb begin
    w_nextState       = r_state;
    ALU_control_lines = 4'b0000;
    ALUsrc            = 1'b0;
    ir_write          = 1'b0;
    pc_write          = 1'b0;
    pc_src            = 1'b0;
    reg_write         = 1'b0;
    reg_dst           = 1'b0;
    mem_to_reg        = 1'b0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    illegal           = 1'b0;
    case (r_state)
      FETCH: begin
        if (w_accept) begin
          ir_write    = 1'b1;
          pc_write    = 1'b1;
          w_nextState = DECODE;
        end
      end
      DECODE: begin
        if (w_isLegal) begin
          w_nextState = EXEC;
        end else begin
          illegal     = 1'b1;
          w_nextState = FETCH;
        end
      end
      EXEC: begin
        ALU_control_lines = w_aluOp;
        ALUsrc            = w_useImm;
        if (w_isBeq) begin
          pc_write    = zero;
          pc_src      = zero;
          w_nextState = FETCH;
        end else if (w_isLw || w_isSw) begin
          w_nextState = MEM;
        end else begin
          w_nextState = WB;
        end
      end
      MEM: begin
        ALU_control_lines = w_aluOp;
        ALUsrc            = w_useImm;
        mem_read          = w_isLw;
        mem_write         = w_isSw;
        if (mem_ready) w_nextState = w_isLw ? WB : FETCH;
      end
      WB: begin
        ALU_control_lines = w_aluOp;
        ALUsrc            = w_useImm;
        reg_write         = 1'b1;
        reg_dst           = w_isRtype;
        mem_to_reg        = w_isLw;
        w_nextState       = FETCH;
      end
      default: begin
        w_nextState = FETCH;
      end
    endcase
  end

  assign state = r_state;

`ifdef MC_PERF_CNT_EN
  logic w_retireNow;
  logic w_stallNow;

  assign w_retireNow = (r_state == WB) ||
                       ((r_state == MEM) && w_isSw && mem_ready) ||
                       ((r_state == EXEC) && w_isBeq);
  assign w_stallNow  = ((r_state == FETCH) && !instr_valid) ||
                       ((r_state == MEM) && !mem_ready);

  // Retired-instruction and stall counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired      <= 32'd0;
      stall_cycles <= 32'd0;
    end else begin
      if (w_retireNow) retired      <= retired + 32'd1;
      if (w_stallNow)  stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
// Self-checking bench for mips_multicycle_ctrl. For each instruction, a
// behavioural model expands the instruction class into its per-cycle
// expected outputs and puts them in a queue. A single compare process checks
// the DUT against that queue on every falling edge. Directed cases pin
// latencies and pulse counts to literal values. Randomised cases mix legal
// and illegal encodings, instruction waits, memory waits and noise on the
// ignored inputs.

module tb_mips_multicycle_ctrl;

  localparam int K_ADD  = 0;
  localparam int K_SUB  = 1;
  localparam int K_AND  = 2;
  localparam int K_OR   = 3;
  localparam int K_LW   = 4;
  localparam int K_SW   = 5;
  localparam int K_BEQ  = 6;
  localparam int K_ADDI = 7;
  localparam int K_ILL  = 8;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] alu;
    logic       alusrc;
    logic       irw;
    logic       pcw;
    logic       pcs;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic       mr;
    logic       mw;
    logic       ill;
  } expT;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        mem_ready;
  logic        zero;
  logic [3:0]  ALU_control_lines;
  logic        ALUsrc, ir_write, pc_write, pc_src, reg_write, reg_dst;
  logic        mem_to_reg, mem_read, mem_write, illegal;
  logic [2:0]  state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] retired;
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.IW(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .instruction       (instruction),
    .instr_valid       (instr_valid),
    .mem_ready         (mem_ready),
    .zero              (zero),
    .ALU_control_lines (ALU_control_lines),
    .ALUsrc            (ALUsrc),
    .ir_write          (ir_write),
    .pc_write          (pc_write),
    .pc_src            (pc_src),
    .reg_write         (reg_write),
    .reg_dst           (reg_dst),
    .mem_to_reg        (mem_to_reg),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .illegal           (illegal),
    .state             (state)
`ifdef MC_PERF_CNT_EN
    ,
    .retired           (retired),
    .stall_cycles      (stall_cycles)
`endif
  );

  expT actVec;
  assign actVec = {state, ALU_control_lines, ALUsrc, ir_write, pc_write, pc_src,
                   reg_write, reg_dst, mem_to_reg, mem_read, mem_write, illegal};

  int    checks = 0;
  int    passes = 0;
  expT   expQ[$];
  string nameQ[$];
  int    busyCycles = 0;
  int    memReadCycles = 0;
  int    takenCycles = 0;
  int    modelRetired = 0;
  int    modelStalls = 0;

  task automatic checkOutput(input string nm, input expT act, input expT exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %b required %b (st|alu|src|irw|pcw|pcs|rw|rd|m2r|mr|mw|ill)",
                  nm, act, exp);
  endtask

  task automatic checkInt(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d required %0d", nm, act, exp);
  endtask

  // Compare process: one expected record per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      expT   e;
      string n;
      e = expQ.pop_front();
      n = nameQ.pop_front();
      checkOutput(n, actVec, e);
      if (state != 3'd0) busyCycles++;
      if (mem_read) memReadCycles++;
      if (state == 3'd2 && pc_write && pc_src) takenCycles++;
    end
  end

  function automatic int classify(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h20:   return K_ADD;
        6'h22:   return K_SUB;
        6'h24:   return K_AND;
        6'h25:   return K_OR;
        default: return K_ILL;
      endcase
    end
    case (op)
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h08:   return K_ADDI;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] aluFor(input int k);
    case (k)
      K_SUB, K_BEQ: return 4'b0110;
      K_AND:        return 4'b0000;
      K_OR:         return 4'b0001;
      default:      return 4'b0010;
    endcase
  endfunction

  task automatic pushExp(input expT e, input string n);
    expQ.push_back(e);
    nameQ.push_back(n);
  endtask

  task automatic driveNoise();
    instruction = $urandom;
    instr_valid = 1'($urandom_range(0, 1));
    mem_ready   = 1'($urandom_range(0, 1));
    zero        = 1'($urandom_range(0, 1));
  endtask

  // Runs one instruction through the model, driving inputs cycle by cycle.
  task automatic applyStimulus(input logic [31:0] ins, input int fetchWait,
                               input int memWait, input logic zeroVal,
                               input bit abortInMem);
    int   k;
    expT  e;
    expT  base;
    k = classify(ins);
    base = '0;
    base.alu    = aluFor(k);
    base.alusrc = (k == K_LW || k == K_SW || k == K_ADDI);

    for (int i = 0; i < fetchWait; i++) begin
      @(posedge clk); #1;
      driveNoise();
      instr_valid = 1'b0;
      pushExp('0, "fetch-wait");
      modelStalls++;
    end

    @(posedge clk); #1;
    driveNoise();
    instruction = ins;
    instr_valid = 1'b1;
    e = '0; e.irw = 1'b1; e.pcw = 1'b1;
    pushExp(e, "fetch-accept");

    @(posedge clk); #1;
    driveNoise();
    e = '0; e.st = 3'd1; e.ill = (k == K_ILL);
    pushExp(e, "decode");
    if (k == K_ILL) return;

    @(posedge clk); #1;
    driveNoise();
    zero = zeroVal;
    e = base; e.st = 3'd2;
    if (k == K_BEQ) begin
      e.pcw = zeroVal;
      e.pcs = zeroVal;
    end
    pushExp(e, "exec");
    if (k == K_BEQ) begin
      modelRetired++;
      return;
    end

    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= memWait; i++) begin
        @(posedge clk); #1;
        driveNoise();
        mem_ready = (i == memWait);
        e = base; e.st = 3'd3; e.mr = (k == K_LW); e.mw = (k == K_SW);
        pushExp(e, "mem");
        if (!mem_ready) modelStalls++;
        if (abortInMem) begin
          @(negedge clk); #1;
          rst = 1'b1;
          instr_valid = 1'b0;
          #1;
          checkOutput("async-reset-outputs", actVec, '0);
          modelRetired = 0;
          modelStalls  = 0;
`ifdef MC_PERF_CNT_EN
          checkInt("async-reset-retired", retired, 0);
`endif
          @(posedge clk); #1;
          rst = 1'b0;
          instruction = 32'h00221820;
          instr_valid = 1'b1;
          pushExp('0, "post-reset-hold");
          return;
        end
      end
      if (k == K_SW) begin
        modelRetired++;
        return;
      end
    end

    @(posedge clk); #1;
    driveNoise();
    e = base; e.st = 3'd4; e.rw = 1'b1;
    e.rd  = (k == K_ADD || k == K_SUB || k == K_AND || k == K_OR);
    e.m2r = (k == K_LW);
    pushExp(e, "wb");
    modelRetired++;
  endtask

  // Waits for the compare process to consume the last pushed record.
  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic clearCounts();
    busyCycles = 0; memReadCycles = 0; takenCycles = 0;
  endtask

  function automatic logic [31:0] randomInstr();
    logic [31:0] ins;
    logic [5:0]  f;
    logic [5:0]  op;
    int          sel;
    ins = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2, 3: begin
        case (sel)
          0: f = 6'h20;
          1: f = 6'h22;
          2: f = 6'h24;
          default: f = 6'h25;
        endcase
        ins[31:26] = 6'h00;
        ins[5:0]   = f;
      end
      4: ins[31:26] = 6'h23;
      5: ins[31:26] = 6'h2B;
      6: ins[31:26] = 6'h04;
      7: ins[31:26] = 6'h08;
      8: begin
        do op = 6'($urandom_range(0, 63));
        while (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h08);
        ins[31:26] = op;
      end
      default: begin
        do f = 6'($urandom_range(0, 63));
        while (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25);
        ins[31:26] = 6'h00;
        ins[5:0]   = f;
      end
    endcase
    return ins;
  endfunction

  initial begin
    rst = 1'b1;
    instruction = 32'h0;
    instr_valid = 1'b1;
    mem_ready = 1'b0;
    zero = 1'b0;

    // Reset state, including instr_valid held high during reset.
    @(negedge clk); #1;
    checkOutput("reset-outputs", actVec, '0);
`ifdef MC_PERF_CNT_EN
    checkInt("reset-retired", retired, 0);
    checkInt("reset-stalls", stall_cycles, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    instruction = 32'h00221820;
    instr_valid = 1'b1;
    pushExp('0, "post-reset-hold");

    // add, then sw with two memory stalls, then an illegal opcode.
    clearCounts();
    applyStimulus(32'h00221820, 0, 0, 1'b0, 1'b0);
    settle();
    checkInt("add-latency", busyCycles + 1, 4);
    applyStimulus(32'hAC220004, 0, 2, 1'b0, 1'b0);
    applyStimulus(32'hFC000000, 0, 0, 1'b0, 1'b0);
    settle();
`ifdef MC_PERF_CNT_EN
    checkInt("perf-retired", retired, 2);
    checkInt("perf-stalls", stall_cycles, 2);
`endif

    clearCounts();
    applyStimulus(32'h8C220004, 0, 3, 1'b0, 1'b0);
    settle();
    checkInt("lw-latency", busyCycles + 1, 8);
    checkInt("lw-memread-cycles", memReadCycles, 4);

    clearCounts();
    applyStimulus(32'h10220003, 0, 0, 1'b1, 1'b0);
    settle();
    checkInt("beq-taken-latency", busyCycles + 1, 3);
    checkInt("beq-taken-pcwrite", takenCycles, 1);

    clearCounts();
    applyStimulus(32'h10220003, 0, 0, 1'b0, 1'b0);
    settle();
    checkInt("beq-nottaken-latency", busyCycles + 1, 3);
    checkInt("beq-nottaken-pcwrite", takenCycles, 0);

    clearCounts();
    applyStimulus(32'h0022182A, 0, 0, 1'b0, 1'b0);
    settle();
    checkInt("illegal-funct-latency", busyCycles + 1, 2);

    clearCounts();
    applyStimulus(32'hAC220004, 0, 0, 1'b0, 1'b0);
    settle();
    checkInt("sw-latency", busyCycles + 1, 4);

    // sw interrupted by reset in MEM, then a normal instruction.
    applyStimulus(32'hAC220008, 0, 3, 1'b0, 1'b1);
    clearCounts();
    applyStimulus(32'h20410005, 0, 0, 1'b0, 1'b0);
    settle();
    checkInt("addi-after-reset-latency", busyCycles + 1, 4);

    // Randomised mix.
    for (int n = 0; n < 150; n++) begin
      applyStimulus(randomInstr(), $urandom_range(0, 2), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'b0);
    end

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      instruction = $urandom;
      instr_valid = 1'b0;
      mem_ready   = 1'($urandom_range(0, 1));
      pushExp('0, "idle");
      modelStalls++;
    end
    settle();
    checkInt("queue-drained", expQ.size(), 0);
`ifdef MC_PERF_CNT_EN
    checkInt("final-retired", retired, modelRetired);
    checkInt("final-stalls", stall_cycles, modelStalls);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle control FSM that drives the execute stage: sequences fetch, decode, execute, memory and writeback for one instruction at a time.
- Produces ALU_control_lines and ALUsrc for the ALU, consumes its zero flag, and issues register-file and data-memory strobes.
- Sits between instruction memory and the datapath (register file, execute, data memory, PC register).

Parameters:
- IW, 32, instruction word width; opcode is [31:26], funct is [5:0].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- instruction  input  IW  instruction word from instruction memory
- instr_valid  input  1  instruction word valid this cycle
- mem_ready  input  1  data memory has completed the access
- zero  input  1  ALU zero flag from the execute stage
- ALU_control_lines  output  4  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
- ALUsrc  output  1  1 selects the immediate as second ALU source
- ir_write  output  1  latch instruction register
- pc_write  output  1  update PC
- pc_src  output  1  0 = PC+4, 1 = branch target
- reg_write  output  1  register-file write strobe
- reg_dst  output  1  1 = rd, 0 = rt
- mem_to_reg  output  1  1 = writeback data from memory
- mem_read  output  1  data memory read request
- mem_write  output  1  data memory write request
- illegal  output  1  one-cycle pulse on an unsupported encoding
- state  output  3  current FSM state, for debug

Behaviour:
- Reset (asynchronous): state goes to FETCH; every output goes to 0; the latched opcode and funct are cleared.
- Reset asserted mid-instruction aborts the instruction; no write strobe may fire in the reset cycle or the cycle after deassertion.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- FETCH: holds until instr_valid=1. In that cycle, pulse ir_write=1 and pc_write=1 with pc_src=0, latch opcode/funct, then go to DECODE.
- DECODE (1 cycle), supported encodings:
  - R-type (opcode 000000) with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08
- DECODE on any other encoding: pulse illegal=1 for 1 cycle, issue no writes, return to FETCH.
- EXEC (1 cycle):
  - R-type: ALUsrc=0, ALU op from funct (add→0010, sub→0110, and→0000, or→0001); next state WB.
  - lw/sw/addi: ALUsrc=1, ALU op 0010; lw/sw go to MEM, addi goes to WB.
  - beq: ALUsrc=0, ALU op 0110. If zero=1, pulse pc_write=1 with pc_src=1. Next state FETCH.
- MEM: assert mem_read (lw) or mem_write (sw) continuously until mem_ready=1, sampled at the clock edge.
  - lw then goes to WB; sw goes to FETCH.
  - mem_ready=1 on the first MEM cycle gives a 1-cycle MEM.
- WB (1 cycle): reg_write=1.
  - R-type: reg_dst=1, mem_to_reg=0.
  - addi: reg_dst=0, mem_to_reg=0.
  - lw: reg_dst=0, mem_to_reg=1.
  - Next state FETCH.
- Output rules:
  - ALU_control_lines and ALUsrc are held stable throughout EXEC, MEM and WB of an instruction; they are 0 in FETCH and DECODE.
  - All strobes are decoded from the registered state plus the latched opcode and funct; no combinational path from instruction to outputs.
  - Strobes are 0 in every state not listed above.
- Latency with instr_valid and mem_ready immediate: R-type/addi 4 cycles, lw 5, sw 4, beq 3, illegal 2.
- instr_valid is ignored outside FETCH; mem_ready is ignored outside MEM.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- Defined:
  - Adds output retired [31:0], cleared by rst. It increments once per completed legal instruction: on the WB cycle, the sw MEM exit cycle, and the beq EXEC cycle. It wraps from 0xFFFFFFFF to 0.
  - Adds output stall_cycles [31:0]. It increments each cycle in FETCH with instr_valid=0 and each cycle in MEM with mem_ready=0.
- Not defined: neither port exists; behaviour is otherwise identical.

Test Plan:
- add $3,$1,$2 (0x00221820), instr_valid=1 → states 0,1,2,4; ALU_control_lines=0010, ALUsrc=0 in EXEC; reg_write=1, reg_dst=1 in WB; total 4 cycles.
- lw (0x8C220004), mem_ready low 3 cycles → mem_read=1 for 4 MEM cycles; WB asserts reg_write=1, mem_to_reg=1; ALUsrc=1 throughout EXEC to WB.
- beq (0x10220003), zero=1 then repeated with zero=0 → pc_write=1, pc_src=1 in EXEC only when zero=1; returns to FETCH after 3 cycles in both cases.
- Opcode 0x3F, and R-type funct 0x2A → illegal pulses 1 cycle in DECODE; reg_write, mem_write and pc_write stay 0; next state FETCH.
- rst asserted during MEM of sw with mem_write=1 → mem_write and all outputs drop to 0 asynchronously; state=0; the next instruction executes normally.
- With MC_PERF_CNT_EN: add, sw with 2 stall cycles, illegal → retired=2, stall_cycles=2.
